reg_status_file: RTL

REG_STATUS_FILE -- requirements
Module: reg_status_file

---
 rtl/reg_status_file.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/reg_status_file.sv
// rtl/reg_status_file.sv - register status file with rename busy/tag tracking and commit writes
//
// Purpose:
//   Architectural register file where each entry holds {data, busy, tag}.
//   Rename marks a register busy and records the ROB tag of its producer.
//   Commit writes data and retires the busy bit only when the committing tag
//   is still the newest producer. Flush drops all speculative busy state.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   raddr / rdata          NUM_RD read ports, address registered, 1-cycle latency
//   ren0/1, rnaddr0/1,
//   rntag0/1               rename-allocate strobes, destination, ROB tag
//   wen0/1, waddr0/1,
//   wdata0/1, wtag0/1      commit-write strobes, destination, data, ROB tag
//   flush                  misprediction recovery
//   busy_cnt, all_idle     registered busy-entry count and its zero flag

module reg_status_file #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 16,
  parameter int TAG_W    = 6,
  parameter int NUM_RD   = 8
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NUM_RD*$clog2(NUM_REGS)-1:0]       raddr,
  output logic [NUM_RD*(DATA_W+1+TAG_W)-1:0]       rdata,
  input  logic                                     ren0,
  input  logic                                     ren1,
  input  logic [$clog2(NUM_REGS)-1:0]              rnaddr0,
  input  logic [$clog2(NUM_REGS)-1:0]              rnaddr1,
  input  logic [TAG_W-1:0]                         rntag0,
  input  logic [TAG_W-1:0]                         rntag1,
  input  logic                                     wen0,
  input  logic                                     wen1,
  input  logic [$clog2(NUM_REGS)-1:0]              waddr0,
  input  logic [$clog2(NUM_REGS)-1:0]              waddr1,
  input  logic [DATA_W-1:0]                        wdata0,
  input  logic [DATA_W-1:0]                        wdata1,
  input  logic [TAG_W-1:0]                         wtag0,
  input  logic [TAG_W-1:0]                         wtag1,
  input  logic                                     flush,
  output logic [$clog2(NUM_REGS+1)-1:0]            busy_cnt,
  output logic                                     all_idle
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int EW = DATA_W + 1 + TAG_W;
  localparam int CW = $clog2(NUM_REGS + 1);

  logic [DATA_W-1:0]      data_q [NUM_REGS];
  logic [DATA_W-1:0]      data_d [NUM_REGS];
  logic [TAG_W-1:0]       tag_q  [NUM_REGS];
  logic [TAG_W-1:0]       tag_d  [NUM_REGS];
  logic [NUM_REGS-1:0]    busy_q;
  logic [NUM_REGS-1:0]    busy_d;
  logic [NUM_RD*AW-1:0]   raddr_q;
  logic [NUM_RD*AW-1:0]   raddr_d;
  logic [CW-1:0]          busy_cnt_q;
  logic [CW-1:0]          busy_cnt_d;
  logic                   all_idle_q;
  logic                   all_idle_d;

  // One-hot decode of every strobe onto the entry array.
  logic [NUM_REGS-1:0]    ren0_hit;
  logic [NUM_REGS-1:0]    ren1_hit;
  logic [NUM_REGS-1:0]    wen0_hit;
  logic [NUM_REGS-1:0]    wen1_hit;

  always_comb begin
    ren0_hit = '0;
    ren1_hit = '0;
    wen0_hit = '0;
    wen1_hit = '0;
    // Renames are speculative and are dropped in a flush cycle.
    if (ren0 && !flush) ren0_hit[rnaddr0] = 1'b1;
    if (ren1 && !flush) ren1_hit[rnaddr1] = 1'b1;
    // Commits are architectural, so their data lands even during a flush.
    if (wen0) wen0_hit[waddr0] = 1'b1;
    if (wen1) wen1_hit[waddr1] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      data_d[i] = data_q[i];
      tag_d[i]  = tag_q[i];
      busy_d[i] = busy_q[i];

      // Port 1 is the younger commit, so it wins a same-register collision.
      if (wen0_hit[i]) data_d[i] = wdata0;
      if (wen1_hit[i]) data_d[i] = wdata1;

      if (flush) begin
        busy_d[i] = 1'b0;
      end else if (ren0_hit[i] || ren1_hit[i]) begin
        // A new producer keeps the entry busy regardless of any commit.
        busy_d[i] = 1'b1;
      end else if (busy_q[i] &&
                   ((wen0_hit[i] && (tag_q[i] == wtag0)) ||
                    (wen1_hit[i] && (tag_q[i] == wtag1)))) begin
        // Only the newest producer may retire the busy bit; stale commits
        // (tag already overwritten by a later rename) leave it set.
        busy_d[i] = 1'b0;
      end

      if (ren1_hit[i]) begin
        tag_d[i] = rntag1;
      end else if (ren0_hit[i]) begin
        tag_d[i] = rntag0;
      end
    end
  end

  always_comb begin
    busy_cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_cnt_d = busy_cnt_d + CW'(busy_d[i]);
    end
    all_idle_d = (busy_cnt_d == '0);
  end

  assign raddr_d = raddr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      busy_q     <= '0;
      raddr_q    <= '0;
      busy_cnt_q <= '0;
      all_idle_q <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        data_q[i] <= data_d[i];
        tag_q[i]  <= tag_d[i];
      end
      busy_q     <= busy_d;
      raddr_q    <= raddr_d;
      busy_cnt_q <= busy_cnt_d;
      all_idle_q <= all_idle_d;
    end
  end

  // Reads look at post-edge state through the registered address, so a
  // write and an address capture on the same edge are seen together.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr_q[k*AW +: AW];
    assign rdata[k*EW +: EW] = {data_q[ra], busy_q[ra], tag_q[ra]};
  end

  assign busy_cnt = busy_cnt_q;
  assign all_idle = all_idle_q;

endmodule
